// File: rtl/centroid_pkg.sv
// Shared types and helpers for the centroid tracker.
//   state_e       : frame FSM states (idle, accumulate, divide)
//   div_cnt_width : width of a divider iteration counter for a given datapath width
package centroid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DIVIDE
  } state_e;

  function automatic int unsigned div_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle, WIDTH cycles in total.
// Ports:
//   clk      in  clock, posedge
//   rst      in  synchronous active-high reset; aborts any division in flight
//   start    in  load dividend/divisor; the first quotient bit is resolved on this edge
//   dividend in  WIDTH-bit numerator
//   divisor  in  WIDTH-bit denominator (all-ones quotient if zero)
//   quotient out WIDTH-bit result, valid while done is high and held afterwards
//   done     out one-cycle pulse once the last quotient bit has been resolved
module seq_divider
  import centroid_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int unsigned CntW = div_cnt_width(WIDTH);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;

  // Operands of the current step: fresh inputs on start, otherwise the running state.
  logic [WIDTH-1:0] rem_src, quo_src, dvs_src;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_step, quo_step;

  always_comb begin
    rem_src = rem_q;
    quo_src = quo_q;
    dvs_src = dvs_q;
    if (start) begin
      rem_src = '0;
      quo_src = dividend;
      dvs_src = divisor;
    end
    shifted = {rem_src, quo_src[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_src};
    // trial[WIDTH] set means the subtraction went negative: restore.
    if (trial[WIDTH]) begin
      rem_step = shifted[WIDTH-1:0];
      quo_step = {quo_src[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_src[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = rem_step;
      quo_d  = quo_step;
      dvs_d  = divisor;
      cnt_d  = CntW'(WIDTH - 1);
      done_d = (WIDTH == 1);
    end else if (cnt_q != '0) begin
      rem_d  = rem_step;
      quo_d  = quo_step;
      cnt_d  = cnt_q - CntW'(1);
      done_d = (cnt_q == CntW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/centroid_tracker.sv
// Streaming per-frame centroid engine. Accumulates (x,y) of every enabled pixel, and on frame
// end divides both sums by the pixel count with two parallel sequential dividers.
// Optional feature macro: CENTROID_BBOX_EN adds per-frame bounding-box tracking and outputs.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   data_in_x/y, data_enable    pixel coordinates, sampled when data_enable=1
//   data_end                    frame end; a pixel in the same cycle is included
//   centroid_x/y                floor(sum/count) of the last completed frame
//   pixel_count                 pixel count of the last completed frame
//   done                        one-cycle pulse when results update
//   busy                        high while accumulating or dividing
//   overflow                    last frame's pixel counter saturated
//   bbox_min/max_x/y            bounding box of the last frame (CENTROID_BBOX_EN only)
module centroid_tracker
  import centroid_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned INTERNAL_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     data_in_x,
  input  logic [DATA_WIDTH-1:0]     data_in_y,
  input  logic                      data_enable,
  input  logic                      data_end,
  output logic [DATA_WIDTH-1:0]     centroid_x,
  output logic [DATA_WIDTH-1:0]     centroid_y,
  output logic [INTERNAL_WIDTH-1:0] pixel_count,
`ifdef CENTROID_BBOX_EN
  output logic [DATA_WIDTH-1:0]     bbox_min_x,
  output logic [DATA_WIDTH-1:0]     bbox_max_x,
  output logic [DATA_WIDTH-1:0]     bbox_min_y,
  output logic [DATA_WIDTH-1:0]     bbox_max_y,
`endif
  output logic                      done,
  output logic                      busy,
  output logic                      overflow
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned IW = INTERNAL_WIDTH;

  state_e        state_q, state_d;
  logic [IW-1:0] sum_x_q, sum_x_d;
  logic [IW-1:0] sum_y_q, sum_y_d;
  logic [IW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          div_start_q, div_start_d;

  logic [DW-1:0] cent_x_q, cent_x_d;
  logic [DW-1:0] cent_y_q, cent_y_d;
  logic [IW-1:0] pix_cnt_q, pix_cnt_d;
  logic          ovf_out_q, ovf_out_d;
  logic          done_q, done_d;

  logic [IW-1:0] x_ext, y_ext;
  logic [IW-1:0] quot_x, quot_y;
  logic          div_done_x, div_done_y;

  assign x_ext = IW'(data_in_x);
  assign y_ext = IW'(data_in_y);

`ifdef CENTROID_BBOX_EN
  logic [DW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [DW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [DW-1:0] bb_min_x_q, bb_min_x_d, bb_max_x_q, bb_max_x_d;
  logic [DW-1:0] bb_min_y_q, bb_min_y_d, bb_max_y_q, bb_max_y_d;
`endif

  always_comb begin
    state_d     = state_q;
    sum_x_d     = sum_x_q;
    sum_y_d     = sum_y_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    div_start_d = 1'b0;
    cent_x_d    = cent_x_q;
    cent_y_d    = cent_y_q;
    pix_cnt_d   = pix_cnt_q;
    ovf_out_d   = ovf_out_q;
    done_d      = 1'b0;
`ifdef CENTROID_BBOX_EN
    min_x_d     = min_x_q;
    max_x_d     = max_x_q;
    min_y_d     = min_y_q;
    max_y_d     = max_y_q;
    bb_min_x_d  = bb_min_x_q;
    bb_max_x_d  = bb_max_x_q;
    bb_min_y_d  = bb_min_y_q;
    bb_max_y_d  = bb_max_y_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // data_end without a pixel is ignored so a zero-count division never happens.
        if (data_enable) begin
          sum_x_d = x_ext;
          sum_y_d = y_ext;
          count_d = IW'(1);
          ovf_d   = 1'b0;
`ifdef CENTROID_BBOX_EN
          min_x_d = data_in_x;
          max_x_d = data_in_x;
          min_y_d = data_in_y;
          max_y_d = data_in_y;
`endif
          if (data_end) begin
            state_d     = ST_DIVIDE;
            div_start_d = 1'b1;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end

      ST_ACCUM: begin
        if (data_enable) begin
          sum_x_d = sum_x_q + x_ext;
          sum_y_d = sum_y_q + y_ext;
          if (count_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + IW'(1);
          end
`ifdef CENTROID_BBOX_EN
          if (data_in_x < min_x_q) min_x_d = data_in_x;
          if (data_in_x > max_x_q) max_x_d = data_in_x;
          if (data_in_y < min_y_q) min_y_d = data_in_y;
          if (data_in_y > max_y_q) max_y_d = data_in_y;
`endif
        end
        if (data_end) begin
          state_d     = ST_DIVIDE;
          div_start_d = 1'b1;
        end
      end

      ST_DIVIDE: begin
        // Both dividers are started together and finish together.
        if (div_done_x && div_done_y) begin
          cent_x_d   = quot_x[DW-1:0];
          cent_y_d   = quot_y[DW-1:0];
          pix_cnt_d  = count_q;
          ovf_out_d  = ovf_q;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
`ifdef CENTROID_BBOX_EN
          bb_min_x_d = min_x_q;
          bb_max_x_d = max_x_q;
          bb_min_y_d = min_y_q;
          bb_max_y_d = max_y_q;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      div_start_q <= 1'b0;
      cent_x_q    <= '0;
      cent_y_q    <= '0;
      pix_cnt_q   <= '0;
      ovf_out_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef CENTROID_BBOX_EN
      min_x_q     <= '0;
      max_x_q     <= '0;
      min_y_q     <= '0;
      max_y_q     <= '0;
      bb_min_x_q  <= '0;
      bb_max_x_q  <= '0;
      bb_min_y_q  <= '0;
      bb_max_y_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sum_x_q     <= sum_x_d;
      sum_y_q     <= sum_y_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      div_start_q <= div_start_d;
      cent_x_q    <= cent_x_d;
      cent_y_q    <= cent_y_d;
      pix_cnt_q   <= pix_cnt_d;
      ovf_out_q   <= ovf_out_d;
      done_q      <= done_d;
`ifdef CENTROID_BBOX_EN
      min_x_q     <= min_x_d;
      max_x_q     <= max_x_d;
      min_y_q     <= min_y_d;
      max_y_q     <= max_y_d;
      bb_min_x_q  <= bb_min_x_d;
      bb_max_x_q  <= bb_max_x_d;
      bb_min_y_q  <= bb_min_y_d;
      bb_max_y_q  <= bb_max_y_d;
`endif
    end
  end

  // Start is registered so the dividers load on the edge after data_end, once the sums
  // include the final pixel.
  seq_divider #(
    .WIDTH (IW)
  ) u_div_x (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_q),
    .dividend (sum_x_q),
    .divisor  (count_q),
    .quotient (quot_x),
    .done     (div_done_x)
  );

  seq_divider #(
    .WIDTH (IW)
  ) u_div_y (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_q),
    .dividend (sum_y_q),
    .divisor  (count_q),
    .quotient (quot_y),
    .done     (div_done_y)
  );

  // A mean of coordinates never exceeds the largest coordinate, so the upper quotient bits
  // carry no information.
  if (IW > DW) begin : g_quot_unused
    logic unused_quot_hi;
    assign unused_quot_hi = ^{quot_x[IW-1:DW], quot_y[IW-1:DW]};
  end

  assign centroid_x  = cent_x_q;
  assign centroid_y  = cent_y_q;
  assign pixel_count = pix_cnt_q;
  assign overflow    = ovf_out_q;
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef CENTROID_BBOX_EN
  assign bbox_min_x = bb_min_x_q;
  assign bbox_max_x = bb_max_x_q;
  assign bbox_min_y = bb_min_y_q;
  assign bbox_max_y = bb_max_y_q;
`endif

endmodule
